// File: rtl/wb_onewire_master_if.sv
// ============================================================================
// wb_onewire_master_if : Wishbone slave-port signal bundle for the 1-Wire master
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb_onewire_master_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic        wb_ack_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
      output wb_dat_o, wb_ack_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o
   );
endinterface

`default_nettype wire

// File: rtl/wb_onewire_master.sv
// ============================================================================
// wb_onewire_master : Wishbone-mapped 1-Wire bus master (reset, byte write/read)
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_onewire_master #(
   parameter int CLK_FREQ = 100000000
) (
   input  wire logic           clk,
   input  wire logic           reset,
   wb_onewire_master_if.slave  bus,
   output logic                intr,
   inout  wire                 onewire
);

   localparam int US_DIV = CLK_FREQ / 1000000;
   localparam int PRE_W  = $clog2(US_DIV);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RST_LOW  = 3'd1;
   localparam logic [2:0] S_RST_WAIT = 3'd2;
   localparam logic [2:0] S_SLOT     = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   logic [2:0]       r_state;
   logic [PRE_W-1:0] r_pre;
   logic [9:0]       r_t;
   logic [2:0]       r_bit;
   logic             r_busy, r_presence, r_done, r_is_read;
   logic [7:0]       r_txdata, r_shift, r_rxdata;
   logic             r_sync1, r_sync2;
   logic             r_ack;
   logic [31:0]      r_dat;

   logic             w_req, w_cmd_ok, w_tick, w_drive_low;
   logic [1:0]       w_adr;
   logic [9:0]       w_low_len;
   logic             w_unused;

   assign w_req    = bus.wb_stb_i & bus.wb_cyc_i & ~r_ack;
   assign w_adr    = bus.wb_adr_i[3:2];
   assign w_cmd_ok = w_req & bus.wb_we_i & (w_adr == 2'd2) & ~r_busy
                     & (bus.wb_dat_i[1:0] != 2'd3);
   assign w_tick   = (r_pre == PRE_W'(US_DIV - 1));

   // Read slots and write-1 slots share the short 6 us low pulse
   assign w_low_len   = (r_is_read | r_shift[r_bit]) ? 10'd6 : 10'd60;
   assign w_drive_low = (r_state == S_RST_LOW) |
                        ((r_state == S_SLOT) & (r_t < w_low_len));

   assign onewire      = w_drive_low ? 1'b0 : 1'bz;
   assign intr         = r_done;
   assign bus.wb_ack_o = r_ack;
   assign bus.wb_dat_o = r_dat;
   assign w_unused     = ^{bus.wb_sel_i, bus.wb_adr_i[31:4], bus.wb_adr_i[1:0],
                           bus.wb_dat_i[31:8]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pre      <= '0;
         r_t        <= '0;
         r_bit      <= '0;
         r_busy     <= 1'b0;
         r_presence <= 1'b0;
         r_done     <= 1'b0;
         r_is_read  <= 1'b0;
         r_txdata   <= '0;
         r_shift    <= '0;
         r_rxdata   <= '0;
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_ack      <= 1'b0;
         r_dat      <= '0;
      end else begin
         r_sync1 <= onewire;
         r_sync2 <= r_sync1;
         r_ack   <= w_req;

         if (w_req) begin
            if (bus.wb_we_i) begin
               if (w_adr == 2'd1) r_txdata <= bus.wb_dat_i[7:0];
            end else begin
               case (w_adr)
                  2'd0: begin
                     r_dat  <= {29'd0, r_done, r_presence, r_busy};
                     r_done <= 1'b0;
                  end
                  2'd1:    r_dat <= {24'd0, r_rxdata};
                  default: r_dat <= '0;
               endcase
            end
         end

         if (r_state == S_IDLE || w_tick) r_pre <= '0;
         else                             r_pre <= r_pre + 1'b1;
         if (w_tick) r_t <= r_t + 10'd1;

         // FSM updates follow the bus logic so a done set wins over a STATUS clear
         case (r_state)
            S_RST_LOW: begin
               if (w_tick && r_t == 10'd479) begin
                  r_state <= S_RST_WAIT;
                  r_t     <= '0;
               end
            end
            S_RST_WAIT: begin
               if (r_t == 10'd70 && r_pre == '0) r_presence <= ~r_sync2;
               if (w_tick && r_t == 10'd409) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_SLOT: begin
               if (r_is_read && r_t == 10'd15 && r_pre == '0)
                  r_rxdata[r_bit] <= r_sync2;
               if (w_tick && r_t == 10'd69) begin
                  r_t <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         if (w_cmd_ok) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pre     <= '0;
            r_t       <= '0;
            r_bit     <= '0;
            r_shift   <= r_txdata;
            r_is_read <= (bus.wb_dat_i[1:0] == 2'd2);
            r_state   <= (bus.wb_dat_i[1:0] == 2'd0) ? S_RST_LOW : S_SLOT;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_onewire_master.sv
// ============================================================================
// tb_wb_onewire_master : randomized self-checking bench with 1-Wire slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_onewire_master;
   localparam int D    = 8;          // clocks per microsecond at 8 MHz
   localparam int HOLD = 20 * D;     // slave low time when answering a 0 bit

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic intr;
   wire  ow;

   wb_onewire_master_if bus();

   wb_onewire_master #(.CLK_FREQ(8000000)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .intr    (intr),
      .onewire (ow)
   );

   always #5 clk = ~clk;

   // Line: open drain with pull-up, shared by DUT and slave model
   logic sl_low = 1'b0;
   logic pr_active = 1'b0;
   int   pr_cnt = 0, pr_start = 0, pr_end = 0;
   logic pres_mode = 1'b0;
   logic rd_mode = 1'b0;
   logic [7:0] rd_byte = 8'h00;
   int   rd_idx = 0, sl_cnt = 0, run = 0;
   logic ow_prev = 1'b1, ow_now;
   int   q_pulse[$];
   int unsigned cyc = 0;
   int   n_checks = 0, n_errors = 0;

   pullup (ow);
   assign ow = (sl_low || (pr_active && pr_cnt >= pr_start * D)) ? 1'b0 : 1'bz;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      ow_now = ow;
      if (!ow_now) run++;
      else if (run > 0) begin
         q_pulse.push_back(run);
         if (pres_mode && run == 480 * D) begin
            pr_active = 1'b1;
            pr_cnt = 0;
         end
         run = 0;
      end
      if (pr_active) begin
         pr_cnt++;
         if (pr_cnt >= pr_end * D) pr_active = 1'b0;
      end
      if (sl_cnt > 0) begin
         sl_cnt--;
         if (sl_cnt == 0) sl_low = 1'b0;
      end else if (rd_mode && !ow_now && ow_prev && rd_idx < 8) begin
         if (!rd_byte[rd_idx]) begin
            sl_low = 1'b1;
            sl_cnt = HOLD - 1;
         end
         rd_idx++;
      end
      ow_prev = ow_now;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
      int k;
      @(negedge clk);
      bus.wb_adr_i = {28'd0, a, 2'b00};
      bus.wb_dat_i = d;
      bus.wb_we_i  = we;
      bus.wb_sel_i = 4'hF;
      bus.wb_stb_i = 1'b1;
      bus.wb_cyc_i = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.wb_ack_o && k < 20);
      if (!bus.wb_ack_o) check("ack_timeout", 32'd0, 32'd1);
      rd = bus.wb_dat_o;
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wait_intr(input int unsigned t0, output int unsigned dur);
      int k = 0;
      while (!intr && k < 1000 * D) begin
         @(negedge clk);
         k++;
      end
      if (!intr) check("intr_timeout", 32'd0, 32'd1);
      dur = cyc - t0;
   endtask

   // Reference model: expected line low time (clocks) for slot i
   function automatic int exp_width(input logic is_read, input logic [7:0] b, input int i);
      if (is_read) return b[i] ? 6 * D : HOLD;
      return b[i] ? 6 * D : 60 * D;
   endfunction

   logic [31:0] rdv;
   int unsigned t0, dur;
   logic exp_pres = 1'b0;
   logic [7:0] bval;

   initial begin
      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
      bus.wb_sel_i = 4'hF; bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
      check("rst_dat", bus.wb_dat_o, 32'd0);
      check("rst_intr", {31'd0, intr}, 32'd0);
      check("rst_line", {31'd0, ow}, 32'd1);
      reset = 1'b0;

      // Bus reset: no slave, then two presence windows
      for (int n = 0; n < 3; n++) begin
         pres_mode = (n != 0);
         pr_start  = (n == 2) ? 80 : 30;
         pr_end    = 150;
         exp_pres  = (n == 1);
         q_pulse.delete();
         wb_xfer(1'b1, 2'd2, 32'd0, rdv);
         t0 = cyc;
         wait_intr(t0, dur);
         check("rst_busy_time", dur, 890 * D);
         check("rst_low_width", (q_pulse.size() > 0) ? q_pulse[0] : -1, 480 * D);
         check("rst_intr", {31'd0, intr}, 32'd1);
         wb_xfer(1'b0, 2'd0, 32'd0, rdv);
         check("rst_status", rdv, {29'd0, 1'b1, exp_pres, 1'b0});
         @(negedge clk);
         check("intr_clear", {31'd0, intr}, 32'd0);
         wb_xfer(1'b0, 2'd0, 32'd0, rdv);
         check("status_after", rdv, {30'd0, exp_pres, 1'b0});
      end
      pres_mode = 1'b0;

      // Write bytes: 0xA5 then random, with DATA overwritten mid-flight
      for (int n = 0; n < 3; n++) begin
         bval = (n == 0) ? 8'hA5 : 8'($urandom);
         wb_xfer(1'b1, 2'd1, {24'd0, bval}, rdv);
         q_pulse.delete();
         wb_xfer(1'b1, 2'd2, 32'd1, rdv);
         t0 = cyc;
         if (n != 0) begin
            repeat (200 * D) @(negedge clk);
            wb_xfer(1'b1, 2'd1, $urandom, rdv);
         end
         wait_intr(t0, dur);
         check("wr_busy_time", dur, 560 * D);
         check("wr_slots", q_pulse.size(), 8);
         for (int i = 0; i < 8 && i < q_pulse.size(); i++)
            check($sformatf("wr_w%0d_b%0h", i, bval), q_pulse[i], exp_width(1'b0, bval, i));
         wb_xfer(1'b0, 2'd0, 32'd0, rdv);
         check("wr_status", rdv, {29'd0, 1'b1, exp_pres, 1'b0});
      end

      // Read bytes: 0x3C then random; a CMD during the first is ignored
      for (int n = 0; n < 3; n++) begin
         bval = (n == 0) ? 8'h3C : 8'($urandom);
         rd_byte = bval;
         rd_idx  = 0;
         rd_mode = 1'b1;
         q_pulse.delete();
         wb_xfer(1'b1, 2'd2, 32'd2, rdv);
         t0 = cyc;
         if (n == 0) begin
            repeat (100 * D) @(negedge clk);
            wb_xfer(1'b1, 2'd2, 32'd1, rdv);
            @(negedge clk);
            check("ack_one_cycle", {31'd0, bus.wb_ack_o}, 32'd0);
            wb_xfer(1'b0, 2'd0, 32'd0, rdv);
            check("busy_bit", {31'd0, rdv[0]}, 32'd1);
         end
         wait_intr(t0, dur);
         rd_mode = 1'b0;
         check("rd_busy_time", dur, 560 * D);
         check("rd_slots", q_pulse.size(), 8);
         for (int i = 0; i < 8 && i < q_pulse.size(); i++)
            check($sformatf("rd_w%0d_b%0h", i, bval), q_pulse[i], exp_width(1'b1, bval, i));
         wb_xfer(1'b0, 2'd1, 32'd0, rdv);
         check("rd_data", rdv, {24'd0, bval});
         wb_xfer(1'b0, 2'd0, 32'd0, rdv);
         check("rd_status", rdv, {29'd0, 1'b1, exp_pres, 1'b0});
      end

      // Unmapped address
      wb_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, rdv);
      wb_xfer(1'b0, 2'd3, 32'd0, rdv);
      check("unmapped_rd", rdv, 32'd0);

      // Reset asserted 20 us into the reset low phase
      wb_xfer(1'b1, 2'd2, 32'd0, rdv);
      repeat (20 * D) @(negedge clk);
      check("abort_driving", {31'd0, ow}, 32'd0);
      #1 reset = 1'b1;
      #1;
      check("abort_line", {31'd0, ow}, 32'd1);
      check("abort_intr", {31'd0, intr}, 32'd0);
      check("abort_ack", {31'd0, bus.wb_ack_o}, 32'd0);
      check("abort_dat", bus.wb_dat_o, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_pres = 1'b0;
      wb_xfer(1'b0, 2'd0, 32'd0, rdv);
      check("abort_status", rdv, 32'd0);
      q_pulse.delete();
      wb_xfer(1'b1, 2'd2, 32'd0, rdv);
      t0 = cyc;
      wait_intr(t0, dur);
      check("rerst_busy_time", dur, 890 * D);
      check("rerst_low_width", (q_pulse.size() > 0) ? q_pulse[0] : -1, 480 * D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
